// File: rtl/pll_seq_pkg.sv
// Purpose : shared types and default cycle constants for the PLL lock / reset sequencer.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   seq_state_e           - sequencer state encoding, also driven on the debug `state` port
//   CNT_W                 - width of the shared phase cycle counter
//   DEF_*                 - default parameter values for pll_lock_reset_seq
//   cycles_for_us()       - converts a wait in microseconds to whole clk cycles, rounding up
package pll_seq_pkg;

  // Sequencer states. The encoding is visible on the debug port, so the
  // values are pinned explicitly rather than left to the tool.
  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_PWRUP_WAIT = 3'd1,
    ST_INIT_REQ   = 3'd2,
    ST_RUN        = 3'd3
  } seq_state_e;

  localparam int unsigned STATE_W = 3;

  // One counter serves every phase; 17 bits covers the longest default wait
  // (the 65535-cycle init timeout) with headroom.
  localparam int unsigned CNT_W = 17;

  // Clock plan: 27 MHz reference multiplied by 29/7 in the rPLL.
  localparam int unsigned REF_CLK_HZ  = 27_000_000;
  localparam int unsigned PLL_MULT    = 29;
  localparam int unsigned PLL_DIV     = 7;
  localparam int unsigned SYS_CLK_HZ  = REF_CLK_HZ * PLL_MULT / PLL_DIV;

  // SDRAM power-up wait before any command may be issued.
  localparam int unsigned SDRAM_PWRUP_US = 200;

  // Whole clk cycles needed to cover `us` microseconds. Rounds up so the
  // wait is never shorter than the device requirement.
  function automatic int unsigned cycles_for_us(input int unsigned us);
    longint unsigned prod;
    prod = longint'(SYS_CLK_HZ) * longint'(us);
    return int'((prod + 64'd999_999) / 64'd1_000_000);
  endfunction

  localparam int unsigned DEF_SYNC_STAGES         = 2;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_PWRUP_WAIT_CYCLES   = cycles_for_us(SDRAM_PWRUP_US);
  localparam int unsigned DEF_INIT_TIMEOUT_CYCLES = 65535;
  localparam int unsigned DEF_LOSS_CNT_W          = 8;

endpackage

// File: rtl/lock_sync.sv
// Purpose : multi-flop synchroniser bringing an asynchronous level into the clk domain.
// Latency : STAGES clk cycles from async_in to sync_out.
// Backpressure: none; free-running level path.
//
// Ports:
//   clk       - destination clock
//   rst_n     - asynchronous active-low reset, clears every stage to 0
//   async_in  - level from another clock domain (or none)
//   sync_out  - async_in after STAGES flops
module lock_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Purpose : releases system reset once PLL lock is stable, waits SDRAM power-up, then runs the init handshake.
// Latency : outputs registered; lock change reaches outputs SYNC_STAGES+1 cycles after pll_lock moves.
// Backpressure: init request is a level held until sdram_init_done, a lock loss, or the timeout.
//
// Ports:
//   clk             - PLL CLKOUT
//   rst_n           - asynchronous active-low reset
//   pll_lock        - raw PLL LOCK, asynchronous to clk
//   sdram_init_done - SDRAM controller init complete (pulse or level, only looked at in INIT_REQ)
//   sys_rst_n       - active-low reset for downstream logic, deasserts synchronously
//   sdram_init_req  - level request to begin SDRAM init
//   ready           - high only in RUN
//   init_timeout    - sticky: the init handshake timed out at least once since rst_n
//   lock_loss_cnt   - saturating count of lock losses after WAIT_LOCK was left
//   state           - current sequencer state, for debug
module pll_lock_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned PWRUP_WAIT_CYCLES   = DEF_PWRUP_WAIT_CYCLES,
  parameter int unsigned INIT_TIMEOUT_CYCLES = DEF_INIT_TIMEOUT_CYCLES,
  parameter int unsigned LOSS_CNT_W          = DEF_LOSS_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_lock,
  input  logic                  sdram_init_done,
  output logic                  sys_rst_n,
  output logic                  sdram_init_req,
  output logic                  ready,
  output logic                  init_timeout,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [STATE_W-1:0]    state
);

  // Terminal counts: a phase ends on the cycle its counter shows N-1, so the
  // phase lasts exactly N cycles.
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_TIMEOUT_CYCLES - 1);

  logic                  lock_s;

  seq_state_e            state_q;
  seq_state_e            state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [LOSS_CNT_W-1:0] loss_q;
  logic [LOSS_CNT_W-1:0] loss_d;
  logic                  timeout_q;
  logic                  timeout_d;
  logic                  lost;

  logic                  sys_rst_n_q;
  logic                  init_req_q;
  logic                  ready_q;

  lock_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pll_lock),
    .sync_out (lock_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      loss_q      <= '0;
      timeout_q   <= 1'b0;
      sys_rst_n_q <= 1'b0;
      init_req_q  <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loss_q      <= loss_d;
      timeout_q   <= timeout_d;
      // Outputs are decoded from the next state so they change on the same
      // edge as the state register rather than one cycle behind it.
      sys_rst_n_q <= (state_d != ST_WAIT_LOCK);
      init_req_q  <= (state_d == ST_INIT_REQ);
      ready_q     <= (state_d == ST_RUN);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    loss_d    = loss_q;
    timeout_d = timeout_q;
    lost      = 1'b0;

    case (state_q)
      ST_PWRUP_WAIT: begin
        if (!lock_s) begin
          lost    = 1'b1;
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == PWRUP_LAST) begin
          state_d = ST_INIT_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_INIT_REQ: begin
        // Lock loss outranks both a completing handshake and the timeout.
        if (!lock_s) begin
          lost    = 1'b1;
          state_d = ST_WAIT_LOCK;
        end else if (sdram_init_done) begin
          state_d = ST_RUN;
        end else if (cnt_q == INIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (!lock_s) begin
          lost    = 1'b1;
          state_d = ST_WAIT_LOCK;
        end
      end

      // WAIT_LOCK, and any unused code, which is pulled back into WAIT_LOCK.
      default: begin
        state_d = ST_WAIT_LOCK;
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_PWRUP_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    if (lost && (loss_q != {LOSS_CNT_W{1'b1}})) begin
      loss_d = loss_q + 1'b1;
    end

    // Every phase starts timing from zero.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  assign sys_rst_n      = sys_rst_n_q;
  assign sdram_init_req = init_req_q;
  assign ready          = ready_q;
  assign init_timeout   = timeout_q;
  assign lock_loss_cnt  = loss_q;
  assign state          = state_q;

endmodule
